// File: rtl/cpu_pkg.sv
// Shared register-file arbitration types, RF address map and address helpers.
package cpu_pkg;

    localparam logic [4:0] VREG_BASE_ADDR = 5'd8;
    localparam logic [4:0] RO_REG_ADDR    = 5'd17;
    localparam logic [4:0] KEY_REG_ADDR   = 5'd18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        FORCE   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // True when addr falls in the eight-entry vector register window starting at base.
    function automatic logic is_vreg(input logic [4:0] addr, input logic [4:0] base);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= ({1'b0, base} + 6'd7));
    endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO buffering SPART key writes; sticky overflow on dropped pushes.
module key_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on the pointers separates full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: CPU pass-through, deferred/forced VPU bulk commit, buffered SPART keys.
// Optional statistics counters are enabled with `define RF_ARB_STATS_EN.
module rf_write_arbiter
    import cpu_pkg::*;
#(
    parameter logic [4:0]  VREG_BASE   = VREG_BASE_ADDR,
    parameter logic [4:0]  RO_ADDR     = RO_REG_ADDR,
    parameter logic [4:0]  KEY_ADDR    = KEY_REG_ADDR,
    parameter int unsigned MAX_DEFER   = 4,
    parameter int unsigned KFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_CPU_0,
    input  logic        we_CPU_1,
    input  logic [4:0]  wrt_addr_0,
    input  logic [4:0]  wrt_addr_1,
    input  logic        vpu_wr_req,
    input  logic        SPART_we,
    input  logic [4:0]  SPART_keys,
    output logic        rf_we_CPU_0,
    output logic        rf_we_CPU_1,
    output logic        rf_we_VPU,
    output logic        vpu_wr_ack,
    output logic        rf_SPART_we,
    output logic [4:0]  rf_SPART_keys,
    output logic        wb_hold,
    output logic        key_overflow
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0] stat_defer_cycles,
    output logic [7:0]  stat_forced,
    output logic [7:0]  stat_keys_dropped
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_DEFER + 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] defer_cnt;
    logic [CNT_W-1:0] defer_cnt_nxt;
    logic             vpu_commit;
    logic             conflict;
    logic             key_hit;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign conflict = (we_CPU_0 && (is_vreg(wrt_addr_0, VREG_BASE) || wrt_addr_0 == RO_ADDR))
                    | (we_CPU_1 && (is_vreg(wrt_addr_1, VREG_BASE) || wrt_addr_1 == RO_ADDR));
    assign key_hit  = (we_CPU_0 && wrt_addr_0 == KEY_ADDR) | (we_CPU_1 && wrt_addr_1 == KEY_ADDR);

    assign rf_we_CPU_0 = we_CPU_0 & (state != FORCE);
    assign rf_we_CPU_1 = we_CPU_1 & (state != FORCE);
    assign rf_we_VPU   = vpu_commit;
    assign vpu_wr_ack  = vpu_commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            defer_cnt <= '0;
            wb_hold   <= 1'b0;
        end else begin
            state     <= state_nxt;
            defer_cnt <= defer_cnt_nxt;
            wb_hold   <= (state_nxt == FORCE) || (state_nxt == RELEASE);
        end
    end

    always_comb begin
        state_nxt     = state;
        defer_cnt_nxt = defer_cnt;
        vpu_commit    = 1'b0;
        case (state)
            IDLE: begin
                if (vpu_wr_req) state_nxt = ARB;
            end
            ARB: begin
                if (!vpu_wr_req) begin
                    state_nxt     = IDLE;
                    defer_cnt_nxt = '0;
                end else if (!conflict) begin
                    vpu_commit    = 1'b1;
                    state_nxt     = IDLE;
                    defer_cnt_nxt = '0;
                end else begin
                    defer_cnt_nxt = defer_cnt + CNT_W'(1);
                    if (defer_cnt == CNT_W'(MAX_DEFER - 1)) state_nxt = FORCE;
                end
            end
            FORCE: begin
                vpu_commit = 1'b1;
                state_nxt  = RELEASE;
            end
            RELEASE: begin
                state_nxt     = IDLE;
                defer_cnt_nxt = '0;
            end
            default: begin
                state_nxt     = IDLE;
                defer_cnt_nxt = '0;
            end
        endcase
    end

    // Keys drain only when neither writeback port is targeting the key register.
    assign fifo_pop    = ~fifo_empty & ~key_hit;
    assign rf_SPART_we = fifo_pop;

    key_fifo #(
        .DEPTH (KFIFO_DEPTH),
        .WIDTH (5)
    ) u_key_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (SPART_we),
        .push_data (SPART_keys),
        .pop       (fifo_pop),
        .pop_data  (rf_SPART_keys),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (key_overflow)
    );

`ifdef RF_ARB_STATS_EN
    logic key_drop;
    assign key_drop = SPART_we & fifo_full & ~fifo_pop;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_defer_cycles <= '0;
            stat_forced       <= '0;
            stat_keys_dropped <= '0;
        end else begin
            if (state == ARB && vpu_wr_req && conflict && stat_defer_cycles != 16'hFFFF)
                stat_defer_cycles <= stat_defer_cycles + 16'd1;
            if (state == ARB && state_nxt == FORCE && stat_forced != 8'hFF)
                stat_forced <= stat_forced + 8'd1;
            if (key_drop && stat_keys_dropped != 8'hFF)
                stat_keys_dropped <= stat_keys_dropped + 8'd1;
        end
    end
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (default parameters, MAX_DEFER=4, KFIFO_DEPTH=4).
module tb_rf_write_arbiter;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we_CPU_0, we_CPU_1;
    logic [4:0] wrt_addr_0, wrt_addr_1;
    logic       vpu_wr_req;
    logic       SPART_we;
    logic [4:0] SPART_keys;
    logic       rf_we_CPU_0, rf_we_CPU_1, rf_we_VPU, vpu_wr_ack;
    logic       rf_SPART_we;
    logic [4:0] rf_SPART_keys;
    logic       wb_hold, key_overflow;
`ifdef RF_ARB_STATS_EN
    logic [15:0] stat_defer_cycles;
    logic [7:0]  stat_forced, stat_keys_dropped;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] sb_keys[$];

    rf_write_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .we_CPU_0      (we_CPU_0),
        .we_CPU_1      (we_CPU_1),
        .wrt_addr_0    (wrt_addr_0),
        .wrt_addr_1    (wrt_addr_1),
        .vpu_wr_req    (vpu_wr_req),
        .SPART_we      (SPART_we),
        .SPART_keys    (SPART_keys),
        .rf_we_CPU_0   (rf_we_CPU_0),
        .rf_we_CPU_1   (rf_we_CPU_1),
        .rf_we_VPU     (rf_we_VPU),
        .vpu_wr_ack    (vpu_wr_ack),
        .rf_SPART_we   (rf_SPART_we),
        .rf_SPART_keys (rf_SPART_keys),
        .wb_hold       (wb_hold),
        .key_overflow  (key_overflow)
`ifdef RF_ARB_STATS_EN
        ,
        .stat_defer_cycles (stat_defer_cycles),
        .stat_forced       (stat_forced),
        .stat_keys_dropped (stat_keys_dropped)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the edge; checks happen 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic w0, input logic [4:0] a0, input logic w1, input logic [4:0] a1);
        we_CPU_0 = w0; wrt_addr_0 = a0; we_CPU_1 = w1; wrt_addr_1 = a1;
    endtask

    // obs = {rf_we_VPU, vpu_wr_ack, wb_hold, rf_we_CPU_0, rf_we_CPU_1}
    function automatic logic [4:0] obs();
        return {rf_we_VPU, vpu_wr_ack, wb_hold, rf_we_CPU_0, rf_we_CPU_1};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; vpu_wr_req = 1'b0; SPART_we = 1'b0; SPART_keys = '0;
        set_cpu(1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        set_cpu(1'b1, 5'd3, 1'b1, 5'd18);
        #3;
        n_cmp++;
        if (obs() !== 5'b00011) begin n_bad++; $display("FAIL reset_outputs got %b want %b", obs(), 5'b00011); end
        n_cmp++;
        if ({rf_SPART_we, key_overflow} !== 2'b00) begin
            n_bad++; $display("FAIL reset_fifo got %b want 00", {rf_SPART_we, key_overflow});
        end
        tick();
    endtask

    task automatic test_vpu_no_conflict();
        set_cpu(1'b0, 5'd0, 1'b0, 5'd0);
        vpu_wr_req = 1'b1;
        #3;
        n_cmp++;
        if (obs() !== 5'b00000) begin n_bad++; $display("FAIL nc_idle got %b want 00000", obs()); end
        tick(); #3;
        n_cmp++;
        if (obs() !== 5'b11000) begin n_bad++; $display("FAIL nc_ack got %b want 11000", obs()); end
        tick();
        vpu_wr_req = 1'b0;
        #3;
        n_cmp++;
        if (obs() !== 5'b00000) begin n_bad++; $display("FAIL nc_after got %b want 00000", obs()); end
        tick();
    endtask

    // Addresses 20, 16 and 7 sit outside V0..V7/RO; the VPU commits alongside the CPU.
    task automatic test_non_v();
        vpu_wr_req = 1'b1;
        set_cpu(1'b1, 5'd20, 1'b1, 5'd16);
        #3;
        n_cmp++;
        if (obs() !== 5'b00011) begin n_bad++; $display("FAIL nonv_idle got %b want 00011", obs()); end
        tick();
        set_cpu(1'b1, 5'd20, 1'b1, 5'd7);
        #3;
        n_cmp++;
        if (obs() !== 5'b11011) begin n_bad++; $display("FAIL nonv_commit got %b want 11011", obs()); end
        tick();
        vpu_wr_req = 1'b0;
        set_cpu(1'b0, 5'd0, 1'b0, 5'd0);
        #3;
        n_cmp++;
        if (obs() !== 5'b00000) begin n_bad++; $display("FAIL nonv_after got %b want 00000", obs()); end
        tick();
    endtask

    task automatic test_force();
        logic [4:0] exp;
        vpu_wr_req = 1'b1;
        set_cpu(1'b1, 5'd9, 1'b0, 5'd0);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) vpu_wr_req = 1'b0;
            case (c)
                5:       exp = 5'b11100;
                6:       exp = 5'b00110;
                default: exp = 5'b00010;
            endcase
            #3;
            n_cmp++;
            if (obs() !== exp) begin n_bad++; $display("FAIL force_c%0d got %b want %b", c, obs(), exp); end
            tick();
        end
        set_cpu(1'b0, 5'd0, 1'b0, 5'd0);
`ifdef RF_ARB_STATS_EN
        n_cmp++;
        if (stat_forced !== 8'd1 || stat_defer_cycles !== 16'd4) begin
            n_bad++; $display("FAIL force_stats got %0d/%0d want 1/4", stat_forced, stat_defer_cycles);
        end
`endif
    endtask

    // Withdraw after 2 conflict cycles, then re-request: a full MAX_DEFER count must elapse again.
    task automatic test_abort();
        logic [4:0] exp;
        for (int c = 0; c < 13; c++) begin
            vpu_wr_req = (c < 3) || (c >= 5 && c <= 10);
            set_cpu(1'b0, 5'd0, 1'b1, (c < 5) ? 5'd17 : 5'd15);
            case (c)
                10:      exp = 5'b11100;
                11:      exp = 5'b00101;
                default: exp = 5'b00001;
            endcase
            #3;
            n_cmp++;
            if (obs() !== exp) begin n_bad++; $display("FAIL abort_c%0d got %b want %b", c, obs(), exp); end
            tick();
        end
        vpu_wr_req = 1'b0;
        set_cpu(1'b0, 5'd0, 1'b0, 5'd0);
`ifdef RF_ARB_STATS_EN
        n_cmp++;
        if (stat_forced !== 8'd2 || stat_defer_cycles !== 16'd10) begin
            n_bad++; $display("FAIL abort_stats got %0d/%0d want 2/10", stat_forced, stat_defer_cycles);
        end
`endif
    endtask

    // Fill while blocked, then a push+pop on a full FIFO, then drain.
    task automatic test_key_full_pushpop();
        logic exp_we;
        logic [4:0] exp_key;
        sb_keys.delete();
        for (int c = 0; c < 10; c++) begin
            set_cpu(c < 4, 5'd18, 1'b0, 5'd0);
            SPART_we   = (c <= 4);
            SPART_keys = 5'(10 + c);
            exp_we = (sb_keys.size() > 0) && (c >= 4);
            #3;
            n_cmp++;
            if (rf_SPART_we !== exp_we) begin n_bad++; $display("FAIL kfull_we_c%0d got %b want %b", c, rf_SPART_we, exp_we); end
            if (exp_we) begin
                exp_key = sb_keys.pop_front();
                n_cmp++;
                if (rf_SPART_keys !== exp_key) begin
                    n_bad++; $display("FAIL kfull_key_c%0d got %0d want %0d", c, rf_SPART_keys, exp_key);
                end
            end
            if (SPART_we && sb_keys.size() < 4) sb_keys.push_back(SPART_keys);
            n_cmp++;
            if (key_overflow !== 1'b0) begin n_bad++; $display("FAIL kfull_ovf_c%0d got %b want 0", c, key_overflow); end
            tick();
        end
        SPART_we = 1'b0;
    endtask

    task automatic test_key_overflow();
        logic exp_we, exp_ovf;
        logic [4:0] exp_key;
        sb_keys.delete();
        exp_ovf = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_cpu(1'b0, 5'd0, c < 5, 5'd18);
            SPART_we   = (c < 5);
            SPART_keys = 5'(c + 1);
            exp_we = (sb_keys.size() > 0) && (c >= 5);
            #3;
            n_cmp++;
            if (rf_SPART_we !== exp_we) begin n_bad++; $display("FAIL kovf_we_c%0d got %b want %b", c, rf_SPART_we, exp_we); end
            if (exp_we) begin
                exp_key = sb_keys.pop_front();
                n_cmp++;
                if (rf_SPART_keys !== exp_key) begin
                    n_bad++; $display("FAIL kovf_key_c%0d got %0d want %0d", c, rf_SPART_keys, exp_key);
                end
            end
            n_cmp++;
            if (key_overflow !== exp_ovf) begin n_bad++; $display("FAIL kovf_flag_c%0d got %b want %b", c, key_overflow, exp_ovf); end
            if (SPART_we) begin
                if (sb_keys.size() < 4) sb_keys.push_back(SPART_keys);
                else exp_ovf = 1'b1;
            end
            tick();
        end
        SPART_we = 1'b0;
`ifdef RF_ARB_STATS_EN
        n_cmp++;
        if (stat_keys_dropped !== 8'd1) begin n_bad++; $display("FAIL kovf_stats got %0d want 1", stat_keys_dropped); end
`endif
    endtask

    task automatic test_reset_mid_force();
        vpu_wr_req = 1'b1;
        set_cpu(1'b1, 5'd12, 1'b1, 5'd18);
        for (int c = 0; c < 5; c++) begin
            SPART_we = (c == 1); SPART_keys = 5'd7;
            tick();
        end
        SPART_we = 1'b0;
        #3;
        n_cmp++;
        if (obs() !== 5'b11100) begin n_bad++; $display("FAIL rmf_force got %b want 11100", obs()); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vpu_wr_req = 1'b0;
        set_cpu(1'b1, 5'd12, 1'b0, 5'd0);
        #3;
        n_cmp++;
        if (obs() !== 5'b00010) begin n_bad++; $display("FAIL rmf_after got %b want 00010", obs()); end
        n_cmp++;
        if ({rf_SPART_we, key_overflow} !== 2'b00) begin
            n_bad++; $display("FAIL rmf_fifo got %b want 00", {rf_SPART_we, key_overflow});
        end
`ifdef RF_ARB_STATS_EN
        n_cmp++;
        if (stat_forced !== 8'd0 || stat_defer_cycles !== 16'd0 || stat_keys_dropped !== 8'd0) begin
            n_bad++; $display("FAIL rmf_stats got %0d/%0d/%0d want 0/0/0", stat_forced, stat_defer_cycles, stat_keys_dropped);
        end
`endif
        tick();
        set_cpu(1'b0, 5'd0, 1'b0, 5'd0);
        vpu_wr_req = 1'b1;
        #3;
        n_cmp++;
        if (obs() !== 5'b00000) begin n_bad++; $display("FAIL rmf_rereq_idle got %b want 00000", obs()); end
        tick(); #3;
        n_cmp++;
        if (obs() !== 5'b11000) begin n_bad++; $display("FAIL rmf_rereq_ack got %b want 11000", obs()); end
        tick();
        vpu_wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vpu_no_conflict();
        test_non_v();
        test_force();
        test_abort();
        test_key_full_pushpop();
        test_key_overflow();
        test_reset_mid_force();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns every write into the CPU register file. Three requesters share it: the CPU writeback (two ports), the VPU bulk result write (V0–V7 plus RO), and SPART key writes.
- CPU writes pass straight through with priority. A VPU commit waits until no CPU write collides with its register range; after a bounded wait it holds the pipeline and commits.
- SPART key writes are buffered in a small FIFO and drained when no CPU write targets the key register.

Parameters:
- VREG_BASE, 5'd8, RF address of V0; V0–V7 occupy VREG_BASE..VREG_BASE+7.
- RO_ADDR, 5'd17, RF address of the VPU return-object register.
- KEY_ADDR, 5'd18, RF address written by SPART keys.
- MAX_DEFER, 4, conflict cycles tolerated before the pipeline is held.
- KFIFO_DEPTH, 4, SPART key FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- we_CPU_0, we_CPU_1  in  1  writeback write enables
- wrt_addr_0, wrt_addr_1  in  5  writeback addresses
- vpu_wr_req  in  1  VPU has V0–V7/RO results; held until ack
- SPART_we  in  1  one-cycle key strobe
- SPART_keys  in  5  key value
- rf_we_CPU_0, rf_we_CPU_1  out  1  gated CPU enables to the register file
- rf_we_VPU  out  1  bulk write strobe to the register file
- vpu_wr_ack  out  1  one-cycle pulse, coincident with rf_we_VPU
- rf_SPART_we  out  1  key write strobe to the register file
- rf_SPART_keys  out  5  key data to the register file
- wb_hold  out  1  writeback/DEX stall request, OR'd into STALL
- key_overflow  out  1  sticky flag; set when a key is dropped

Behaviour:
- All registered state clears on reset: FSM in IDLE, defer_cnt=0, FIFO empty, key_overflow=0, wb_hold=0.
- Conflict condition: (we_CPU_k & wrt_addr_k ∈ [VREG_BASE, VREG_BASE+7]) | (we_CPU_k & wrt_addr_k==RO_ADDR), for k=0 or 1.
- Pass-through: rf_we_CPU_k = we_CPU_k & ~(state==FORCE). This is combinational, zero latency.
- FSM states:
  - IDLE: if vpu_wr_req, go to ARB. No outputs.
  - ARB:
    - No conflict: rf_we_VPU=vpu_wr_ack=1 (combinational), then go to IDLE with defer_cnt=0.
    - Conflict: defer_cnt++. When defer_cnt==MAX_DEFER-1 with a conflict, go to FORCE.
  - FORCE: wb_hold=1 (registered, asserted the cycle the state is entered) and CPU enables masked. rf_we_VPU=vpu_wr_ack=1 this cycle, then go to RELEASE.
  - RELEASE: wb_hold=1 for one more cycle so the writeback stage re-presents the writes it held, with CPU enables unmasked. Then go to IDLE with defer_cnt=0.
- VPU-path boundary rules:
  - Worst-case commit latency from request is MAX_DEFER+1 cycles.
  - vpu_wr_req dropping in ARB aborts the request: return to IDLE and clear defer_cnt.
  - Behaviour if the request drops in FORCE or RELEASE is undefined.
- Key FIFO:
  - SPART_we pushes SPART_keys.
  - Pop when not empty and no CPU write targets KEY_ADDR. The popped value appears on rf_SPART_keys with rf_SPART_we=1 in the same cycle (first-word-fall-through).
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full with no pop: the key is dropped and key_overflow is set; it clears only on reset.
  - Pointers wrap modulo KFIFO_DEPTH, with an extra occupancy bit to distinguish full from empty.
- Reset mid-FORCE: wb_hold drops the next cycle and the pending VPU request is forgotten. The VPU must re-request.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_defer_cycles[15:0] (ARB cycles spent in conflict), stat_forced[7:0] (FORCE entries) and stat_keys_dropped[7:0].
  - All three saturate and clear on reset.
- Undefined: these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - Arbiter state enum {IDLE, ARB, FORCE, RELEASE}.
  - RF address constants for V0, RO and KEY (supplying the parameter defaults).
  - A helper function is_vreg(addr).
- One sub-module: key_fifo, a parameterised depth/width FWFT FIFO with push, pop, full, empty and overflow outputs.

Test Plan:
- VPU request with no CPU writes → rf_we_VPU and vpu_wr_ack high on the first ARB cycle (cycle 1 after request). wb_hold stays 0.
- CPU writes to address 9 on consecutive cycles with MAX_DEFER=4 → 4 conflict cycles, then FORCE. wb_hold=1 for 2 cycles, rf_we_CPU masked for 1 cycle, and the VPU commits in the FORCE cycle. stat_forced=1 when RF_ARB_STATS_EN is defined.
- CPU writes address 20 (non-V) while the VPU requests → both commit in the same cycle and no stall is raised.
- 5 SPART strobes (keys 1..5) while the CPU writes KEY_ADDR continuously → the first 4 are buffered and key 5 is dropped with key_overflow=1. After the CPU stops, keys 1, 2, 3, 4 drain on 4 consecutive cycles.
- Reset asserted during FORCE → next cycle wb_hold=0, FIFO empty, FSM IDLE.
- vpu_wr_req withdrawn after 2 conflict cycles → no ack, return to IDLE, defer_cnt=0. A new request starts the count from 0.
